viterbi_traceback: RTL and testbench

Parametrised Viterbi traceback unit for the convolutional decoder. It stores one survivor-decision vector per trellis step in an internal buffer, `TB_LEN` vectors deep. On command it traces back from a supplied start state and emits `TB_LEN` decoded bits as one packed word with a one-cycle `done` pulse. It sits between the add-compare-select array, which supplies decisions and the minimum-cost state, and the descrambler/deinterleaver path. Unlike the fixed 64-state, 32-bit single-vector unit, it buffers the decisions itself and supports any constraint length and depth.

---
 rtl/viterbi_traceback.sv | 109 ++++++++++
 tb/tb_viterbi_traceback.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: buffers TB_LEN survivor-decision vectors, then traces back
// from a start state and emits TB_LEN decoded bits. Macro: TB_ZERO_START_EN.
module viterbi_traceback #(
  parameter int unsigned K      = 7,
  parameter int unsigned TB_LEN = 32,
  localparam int unsigned NS    = 1 << (K - 1),
  localparam int unsigned SW    = K - 1,
  localparam int unsigned CW    = $clog2(TB_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [NS-1:0]     decisions,
  input  logic              tb_start,
  input  logic [SW-1:0]     tb_start_state,
  output logic [TB_LEN-1:0] bit_out,
  output logic              done,
  output logic              tb_err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    TRACE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       rd_q;
  logic [CW-1:0]       idx_q;
  logic [SW-1:0]       st_q;
  logic [TB_LEN-1:0]   bit_out_q;
  logic                done_q;
  logic                tb_err_q;
  logic [NS-1:0]       mem_q [TB_LEN];
  logic [SW-1:0]       start_state_c;

  // Zero-tailed frames always terminate in state 0.
`ifdef TB_ZERO_START_EN
  assign start_state_c = '0;
`else
  assign start_state_c = tb_start_state;
`endif

  assign dec_ready = (state_q == FILL);
  assign bit_out   = bit_out_q;
  assign done      = done_q;
  assign tb_err    = tb_err_q;

  // Decision buffer: no reset, written only while filling.
  always_ff @(posedge clk) begin
    if (state_q == FILL && dec_valid) begin
      mem_q[count_q] <= decisions;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      count_q   <= '0;
      rd_q      <= '0;
      idx_q     <= '0;
      st_q      <= '0;
      bit_out_q <= '0;
      done_q    <= 1'b0;
      tb_err_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      tb_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (dec_valid) begin
            if (count_q == CW'(TB_LEN - 1)) begin
              state_q <= FULL;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          if (tb_start) begin
            tb_err_q <= 1'b1;
          end
        end
        FULL: begin
          if (tb_start) begin
            st_q    <= start_state_c;
            rd_q    <= CW'(TB_LEN - 1);
            idx_q   <= CW'(TB_LEN - 1);
            state_q <= TRACE;
          end
        end
        TRACE: begin
          // Newest step first: emit the state LSB, shift in the survivor bit.
          bit_out_q[idx_q] <= st_q[0];
          st_q             <= {mem_q[rd_q][st_q], st_q[SW-1:1]};
          rd_q             <= rd_q - CW'(1);
          idx_q            <= idx_q - CW'(1);
          if (idx_q == '0) begin
            done_q  <= 1'b1;
            count_q <= '0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback (K=7, TB_LEN=32) with an expected-result queue.
module tb_viterbi_traceback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] decisions;
  logic        tb_start;
  logic [5:0]  tb_start_state;
  logic [31:0] bit_out;
  logic        done;
  logic        tb_err;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] sb_q [$];
  logic [63:0] mdl [32];
  int          wr_cnt;

  viterbi_traceback #(.K(7), .TB_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .decisions(decisions), .tb_start(tb_start), .tb_start_state(tb_start_state),
    .bit_out(bit_out), .done(done), .tb_err(tb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference traceback over the vectors the bench saw accepted.
  function automatic logic [31:0] ref_trace(input logic [5:0] s0);
    logic [31:0] r;
    logic [5:0]  st;
    logic [63:0] v;
    st = s0;
    r  = '0;
    for (int i = 31; i >= 0; i--) begin
      r[i] = st[0];
      v    = mdl[i];
      st   = {v[st], st[5:1]};
    end
    return r;
  endfunction

  // Called at a negedge; dec_ready depends on state only, so it predicts acceptance.
  task automatic write_vec(input logic [63:0] v);
    decisions = v;
    dec_valid = 1'b1;
    if (dec_ready === 1'b1) begin
      mdl[wr_cnt] = v;
      wr_cnt++;
    end
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  task automatic run_trace(input logic [5:0] s, input logic [31:0] exp, input string tag);
    int   n;
    logic err_seen;
    logic [31:0] e;
    sb_q.push_back(exp);
    tb_start       = 1'b1;
    tb_start_state = s;
    @(negedge clk);
    tb_start       = 1'b0;
    tb_start_state = ~s;
    check({tag, "_ready_low"}, 32'(dec_ready), 32'd0);
    n = 0;
    err_seen = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      tb_start = (n == 5);
      @(negedge clk);
      err_seen |= tb_err;
      n++;
    end
    tb_start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_no_err"}, 32'(err_seen), 32'd0);
    check({tag, "_ready_at_done"}, 32'(dec_ready), 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 32'hxxxxxxxx;
    check(tag, bit_out, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, bit_out, e);
    wr_cnt = 0;
  endtask

  initial begin
    int acc;
    int low_at;
    logic [5:0] s;
    logic seen_done;
    rst_n = 1'b0; dec_valid = 1'b0; decisions = '0;
    tb_start = 1'b0; tb_start_state = '0; wr_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(dec_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(tb_err), 32'd0);
    check("rst_bits", bit_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero decisions
    for (int i = 0; i < 32; i++) write_vec(64'd0);
    check("full_ready_low", 32'(dec_ready), 32'd0);
    run_trace(6'h00, 32'h00000000, "zeros");

    // All ones from 3F; a write attempt while FULL must be dropped
    for (int i = 0; i < 32; i++) write_vec('1);
    write_vec(64'd0);
    run_trace(6'h3F, 32'hFFFFFFFF, "ones_3f");

    for (int i = 0; i < 32; i++) write_vec('1);
    run_trace(6'h00, 32'h03FFFFFF, "ones_00");

    // Read order: only the newest vector is ones
    for (int i = 0; i < 31; i++) write_vec(64'd0);
    write_vec('1);
    run_trace(6'h00, 32'h02000000, "read_order");

    // Early start after 5 writes
    for (int i = 0; i < 5; i++) write_vec({$urandom, $urandom});
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    check("early_err", 32'(tb_err), 32'd1);
    check("early_ready", 32'(dec_ready), 32'd1);
    @(negedge clk);
    check("early_err_pulse", 32'(tb_err), 32'd0);
    for (int i = 0; i < 26; i++) write_vec({$urandom, $urandom});
    check("early_count_ready", 32'(dec_ready), 32'd1);
    write_vec({$urandom, $urandom});
    check("early_count_full", 32'(dec_ready), 32'd0);
    check("early_count_model", 32'(wr_cnt), 32'd32);
    s = 6'($urandom);
    run_trace(s, ref_trace(s), "early_random");

    // Backpressure: dec_valid held for 40 cycles
    acc = 0;
    low_at = 0;
    dec_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      decisions = {$urandom, $urandom};
      if (dec_ready === 1'b1) begin
        mdl[acc] = decisions;
        acc++;
      end else if (low_at == 0) begin
        low_at = c;
      end
      @(negedge clk);
    end
    dec_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd32);
    check("bp_low_cycle", 32'(low_at), 32'd33);
    check("bp_still_low", 32'(dec_ready), 32'd0);
    s = 6'($urandom);
    run_trace(s, ref_trace(s), "bp_random");

    // Reset on the 10th trace cycle
    for (int i = 0; i < 32; i++) write_vec('1);
    tb_start = 1'b1;
    tb_start_state = 6'h3F;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bits", bit_out, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(dec_ready), 32'd1);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_bits_after", bit_out, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "timeout");
  end

endmodule
